mult_rom_serial_ctrl: RTL and testbench

MULT_ROM_SERIAL_CTRL -- requirements
Module: mult_rom_serial_ctrl

---
 rtl/mult_rom_serial_ctrl.sv | 122 ++++++++++++
 tb/tb_mult_rom_serial_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_rom_serial_ctrl.sv
// Serial nibble multiplier driving an external 4x4 product ROM, one partial product per cycle.
// Optional MULT_ROM_SKIP_ZERO_EN: zero operands finish at the acceptance edge.
module mult_rom_serial_ctrl #(
    parameter int OP_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OP_WIDTH-1:0]     in_a,
    input  logic [OP_WIDTH-1:0]     in_b,
    output logic [7:0]              rom_addr,
    input  logic [7:0]              rom_dout,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*OP_WIDTH-1:0]   out_p,
    output logic                    busy
);

    localparam int N  = OP_WIDTH / 4;
    localparam int NN = N * N;
    localparam int LN = $clog2(N);
    localparam int KW = $clog2(NN);
    localparam int PW = 2 * OP_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [KW-1:0]       r_k;
    logic [OP_WIDTH-1:0] r_a;
    logic [OP_WIDTH-1:0] r_b;
    logic [PW-1:0]       r_acc;
    logic [PW-1:0]       r_out_p;
    logic                r_out_valid;

    logic [LN-1:0]       w_i;
    logic [LN-1:0]       w_j;
    logic [LN:0]         w_sum;
    logic [PW-1:0]       w_term;
    logic [PW-1:0]       w_acc_next;
    logic                w_last;
    logic [7:0]          w_addr;

    // k splits into operand-a nibble (high bits) and operand-b nibble (low bits)
    assign w_i        = r_k[KW-1:LN];
    assign w_j        = r_k[LN-1:0];
    assign w_sum      = {1'b0, w_i} + {1'b0, w_j};
    assign w_term     = {{(PW-8){1'b0}}, rom_dout} << {w_sum, 2'b00};
    assign w_acc_next = r_acc + w_term;
    assign w_last     = (r_k == KW'(NN - 1));

    always_comb begin
        w_addr = 8'h00;
        if (r_state == CALC) begin
            w_addr = {r_a[4*int'(w_i) +: 4], r_b[4*int'(w_j) +: 4]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_out_p     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a   <= in_a;
                        r_b   <= in_b;
                        r_acc <= '0;
                        r_k   <= '0;
`ifdef MULT_ROM_SKIP_ZERO_EN
                        if ((in_a == '0) || (in_b == '0)) begin
                            r_state     <= DONE;
                            r_out_p     <= '0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= CALC;
                        end
`else
                        r_state <= CALC;
`endif
                    end
                end
                CALC: begin
                    r_acc <= w_acc_next;
                    r_k   <= r_k + 1'b1;
                    if (w_last) begin
                        r_state     <= DONE;
                        r_out_p     <= w_acc_next;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign rom_addr  = w_addr;
    assign out_valid = r_out_valid;
    assign out_p     = r_out_p;

endmodule

// File: tb/tb_mult_rom_serial_ctrl.sv
// Scoreboard bench for mult_rom_serial_ctrl: 8-bit instance randomized, 16-bit instance directed.
// Build with or without MULT_ROM_SKIP_ZERO_EN to match the RTL.
module tb_mult_rom_serial_ctrl;

    localparam int W   = 8;
    localparam int N   = W / 4;
    localparam int LAT = N * N;

`ifdef MULT_ROM_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [7:0]   rom_addr;
    logic [7:0]   rom_dout;
    logic         out_valid;
    logic         out_ready;
    logic [2*W-1:0] out_p;
    logic         busy;

    logic         in_valid16;
    logic         in_ready16;
    logic [15:0]  in_a16;
    logic [15:0]  in_b16;
    logic [7:0]   rom_addr16;
    logic [7:0]   rom_dout16;
    logic         out_valid16;
    logic         out_ready16;
    logic [31:0]  out_p16;
    logic         busy16;

    always #5 clk = ~clk;

    // external product ROM
    assign rom_dout   = 8'(rom_addr[7:4]) * 8'(rom_addr[3:0]);
    assign rom_dout16 = 8'(rom_addr16[7:4]) * 8'(rom_addr16[3:0]);

    mult_rom_serial_ctrl #(.OP_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .rom_addr(rom_addr), .rom_dout(rom_dout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .busy(busy)
    );

    mult_rom_serial_ctrl #(.OP_WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .in_a(in_a16), .in_b(in_b16),
        .rom_addr(rom_addr16), .rom_dout(rom_dout16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .out_p(out_p16), .busy(busy16)
    );

    typedef struct {
        logic [31:0] p;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;
    bit   rand_bp = 1'b0;
    logic prev_v = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b, input int full);
        if (SKIP && (a == 0 || b == 0)) return 0;
        return full;
    endfunction

    // monitor: compares each new result against the scoreboard head
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid && !prev_v) begin
                if (sbq.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    cur = sbq.pop_front();
                    check("product", 32'(out_p), cur.p);
                    check("latency", 32'(cyc - cur.acc_cyc), 32'(cur.lat));
                end
            end else if (out_valid) begin
                check("hold_out_p", 32'(out_p), cur.p);
            end
            if (out_valid) check("in_ready_in_done", 32'(in_ready), 32'd0);
            if (out_valid || !busy) check("rom_addr_idle_done", 32'(rom_addr), 32'd0);
            prev_v = out_valid;
        end
    end

    always @(negedge clk) begin
        if (rand_bp) out_ready = ($urandom % 4) != 0;
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit garbage);
        logic rdy;
        exp_t e;
        rdy = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        for (int g = 0; g < 300; g++) begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!rdy) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            e.p       = 32'(a) * 32'(b);
            e.acc_cyc = cyc;
            e.lat     = exp_lat(32'(a), 32'(b), LAT);
            sbq.push_back(e);
            if (garbage && e.lat == LAT) begin
                // operands and valid wiggle while CALC runs; must be ignored
                in_valid = 1'b1;
                for (int g = 0; g < LAT - 1; g++) begin
                    in_a = W'($urandom);
                    in_b = W'($urandom);
                    @(posedge clk);
                    #1;
                end
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic drain();
        int g;
        for (g = 0; g < 500; g++) begin
            if (sbq.size() == 0 && !busy) break;
            @(negedge clk);
        end
        if (g >= 500) check("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b);
        int acc;
        int g;
        @(negedge clk);
        check("in_ready16", 32'(in_ready16), 32'd1);
        in_valid16 = 1'b1;
        in_a16 = a;
        in_b16 = b;
        @(posedge clk);
        #1;
        acc = cyc;
        in_valid16 = 1'b0;
        in_a16 = 16'hA5A5;
        for (g = 0; g < 100; g++) begin
            @(negedge clk);
            if (out_valid16) break;
        end
        if (g >= 100) begin
            check("out_valid16_timeout", 32'd0, 32'd1);
        end else begin
            check("product16", out_p16, 32'(a) * 32'(b));
            check("latency16", 32'(cyc - acc), 32'(exp_lat(32'(a), 32'(b), 16)));
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b1;
        in_valid16 = 1'b0;
        in_a16 = '0;
        in_b16 = '0;
        out_ready16 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_p", 32'(out_p), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // rom address walk for 0x12 * 0x34
        send(8'h12, 8'h34, 1'b0);
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            check("rom_addr_seq",
                  32'(((8'h12 >> (4 * (k / N))) & 4'hF) << 4 | ((8'h34 >> (4 * (k % N))) & 4'hF)),
                  32'(rom_addr));
            check("busy_calc", 32'(busy), 32'd1);
        end
        drain();

        // held result under backpressure
        out_ready = 1'b0;
        send(8'hFF, 8'hFF, 1'b1);
        for (int g = 0; g < 50 && !out_valid; g++) @(negedge clk);
        check("busy_done", 32'(busy), 32'd1);
        repeat (10) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_hs_in_ready", 32'(in_ready), 32'd1);
        check("idle_after_hs_out_valid", 32'(out_valid), 32'd0);
        check("out_p_retained", 32'(out_p), 32'hFE01);

        // reset at CALC step 2 discards the result
        send(8'hAB, 8'hCD, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("step2_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sbq.delete();
        check("rst_mid_out_p", 32'(out_p), 32'd0);
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        send(8'd3, 8'd5, 1'b0);
        drain();

        // zero operand
        send(8'd0, 8'd200, 1'b0);
        drain();

        // randomized traffic with backpressure
        rand_bp = 1'b1;
        for (int t = 0; t < 40; t++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = ($urandom % 8 == 0) ? '0 : W'($urandom);
            b = ($urandom % 8 == 0) ? '0 : W'($urandom);
            send(a, b, 1'b1);
        end
        drain();
        rand_bp = 1'b0;
        out_ready = 1'b1;

        // 16-bit instance
        run16(16'hFFFF, 16'hFFFF);
        run16(16'h0000, 16'h1234);
        for (int t = 0; t < 4; t++) run16(16'($urandom), 16'($urandom));

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
